// File: rtl/spi_axi_lite_arbiter.sv
// Two-client AXI4-Lite master arbiter for the spi_axi register port, one transaction at a time.
// Define SPI_AXI_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module spi_axi_lite_arbiter #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          REQ0_VALID,
  input  logic                          REQ0_WRITE,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   REQ0_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] REQ0_WSTRB,
  output logic                          REQ0_READY,
  input  logic                          REQ1_VALID,
  input  logic                          REQ1_WRITE,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   REQ1_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] REQ1_WSTRB,
  output logic                          REQ1_READY,
  output logic                          RSP0_VALID,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP0_RDATA,
  output logic [1:0]                    RSP0_RESP,
  output logic                          RSP1_VALID,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP1_RDATA,
  output logic [1:0]                    RSP1_RESP,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                    state;
  logic                          run;
  logic                          owner;
  logic                          win;
  logic                          accept;
  logic                          aw_done;
  logic                          w_done;
  logic                          aw_hs;
  logic                          w_hs;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic                          sel_write;
  logic [C_AXI_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_AXI_DATA_WIDTH-1:0]   sel_wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] sel_wstrb;
  logic                          cap_fire;
  logic [C_AXI_DATA_WIDTH-1:0]   cap_rdata;
  logic [1:0]                    cap_resp;

  // win = 1 selects port 1; only meaningful while accept is high
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
  assign win = ~REQ0_VALID;
`else
  logic last;
  assign win = (REQ0_VALID & REQ1_VALID) ? ~last : ~REQ0_VALID;
`endif

  // run keeps READY low while reset is held and for the first edge after release
  assign accept     = run & (state == S_IDLE) & (REQ0_VALID | REQ1_VALID);
  assign REQ0_READY = accept & ~win;
  assign REQ1_READY = accept & win;

  assign sel_write = win ? REQ1_WRITE : REQ0_WRITE;
  assign sel_addr  = win ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata = win ? REQ1_WDATA : REQ0_WDATA;
  assign sel_wstrb = win ? REQ1_WSTRB : REQ0_WSTRB;

  assign aw_hs        = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs         = M_AXI_WVALID & M_AXI_WREADY;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_comb begin
    cap_fire  = 1'b0;
    cap_rdata = '0;
    cap_resp  = M_AXI_BRESP;
    if (state == S_WRESP) begin
      cap_fire = M_AXI_BVALID;
    end else if (state == S_RDATA) begin
      cap_fire  = M_AXI_RVALID;
      cap_rdata = M_AXI_RDATA;
      cap_resp  = M_AXI_RRESP;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      run           <= 1'b0;
      owner         <= 1'b0;
`ifndef SPI_AXI_ARB_FIXED_PRIO_EN
      last          <= 1'b1;
`endif
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      RSP0_VALID    <= 1'b0;
      RSP0_RDATA    <= '0;
      RSP0_RESP     <= 2'b00;
      RSP1_VALID    <= 1'b0;
      RSP1_RDATA    <= '0;
      RSP1_RESP     <= 2'b00;
    end else begin
      run        <= 1'b1;
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner       <= win;
`ifndef SPI_AXI_ARB_FIXED_PRIO_EN
            last        <= win;
`endif
            addr_q      <= sel_addr;
            M_AXI_WDATA <= sel_wdata;
            M_AXI_WSTRB <= sel_wstrb;
            if (sel_write) begin
              state         <= S_WADDR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
            end else begin
              state         <= S_RADDR;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        // AW and W complete independently, in either order
        S_WADDR: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state        <= S_WRESP;
            M_AXI_BREADY <= 1'b1;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            state        <= S_DONE;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            state        <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // response registers load on the completing handshake, so the pulse lands in DONE
      if (cap_fire) begin
        if (owner) begin
          RSP1_VALID <= 1'b1;
          RSP1_RDATA <= cap_rdata;
          RSP1_RESP  <= cap_resp;
        end else begin
          RSP0_VALID <= 1'b1;
          RSP0_RDATA <= cap_rdata;
          RSP0_RESP  <= cap_resp;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_axi_lite_arbiter.sv
// Directed bench for spi_axi_lite_arbiter with a reactive AXI4-Lite register slave (4 x 32-bit).
module tb_spi_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        ARESETN = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ0_WRITE = 1'b0;
  logic [3:0]  REQ0_ADDR = '0, REQ0_WSTRB = '0;
  logic [31:0] REQ0_WDATA = '0;
  logic        REQ1_VALID = 1'b0, REQ1_WRITE = 1'b0;
  logic [3:0]  REQ1_ADDR = '0, REQ1_WSTRB = '0;
  logic [31:0] REQ1_WDATA = '0;
  logic        REQ0_READY, REQ1_READY;
  logic        RSP0_VALID, RSP1_VALID;
  logic [31:0] RSP0_RDATA, RSP1_RDATA;
  logic [1:0]  RSP0_RESP, RSP1_RESP;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model state
  logic [31:0] mem [4];
  int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  logic        force_err = 1'b0;
  logic        got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic [3:0]  aw_addr = '0, ar_addr = '0, w_strb = '0;
  logic [31:0] w_data = '0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
  int          bready_bad = 0, overlap = 0, rsp0_cnt = 0, rsp1_cnt = 0;

  spi_axi_lite_arbiter #(.C_AXI_ADDR_WIDTH(4), .C_AXI_DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_WSTRB(REQ0_WSTRB), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_WSTRB(REQ1_WSTRB), .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA), .RSP0_RESP(RSP0_RESP),
    .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA), .RSP1_RESP(RSP1_RESP),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  // handshake observer: samples pre-edge values at the rising edge
  always @(posedge clk) begin
    cyc++;
    if (ARESETN) begin
      if (M_AXI_BREADY && !(got_aw && got_w)) bready_bad++;
      if ((REQ0_READY && RSP0_VALID) || (REQ1_READY && RSP1_VALID)) overlap++;
      if (RSP0_VALID) rsp0_cnt++;
      if (RSP1_VALID) rsp1_cnt++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_hs_cnt++; got_aw = 1'b1; aw_addr = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_hs_cnt++; got_w = 1'b1; w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin got_aw = 1'b0; got_w = 1'b0; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs_cnt++; got_ar = 1'b1; ar_addr = M_AXI_ARADDR; end
      if (M_AXI_RVALID && M_AXI_RREADY) got_ar = 1'b0;
    end
  end

  // slave drives its outputs on the falling edge
  always @(negedge clk) begin
    if (!ARESETN) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
      got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; aw_wait = 0; w_wait = 0;
    end else begin
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++; end
      else begin M_AXI_AWREADY = 1'b0; aw_wait = 0; end
      if (M_AXI_WVALID) begin M_AXI_WREADY = (w_wait >= w_delay); w_wait++; end
      else begin M_AXI_WREADY = 1'b0; w_wait = 0; end
      if (got_aw && got_w) begin
        if (!M_AXI_BVALID) begin
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) mem[aw_addr[3:2]][b*8 +: 8] = w_data[b*8 +: 8];
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP  = 2'b00;
        end
      end else M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = M_AXI_ARVALID;
      if (got_ar) begin
        if (!M_AXI_RVALID) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RDATA  = force_err ? 32'hDEAD_BEEF : mem[ar_addr[3:2]];
          M_AXI_RRESP  = force_err ? 2'b10 : 2'b00;
        end
      end else begin
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{REQ0_READY, REQ1_READY, RSP0_VALID, RSP0_RDATA, RSP0_RESP, RSP1_VALID, RSP1_RDATA,
             RSP1_RESP, M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
             M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  function automatic logic rdy(input int p);
    return (p != 0) ? REQ1_READY : REQ0_READY;
  endfunction

  function automatic logic rsp(input int p);
    return (p != 0) ? RSP1_VALID : RSP0_VALID;
  endfunction

  task automatic drive(input int p, input logic v, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (p == 0) begin
      REQ0_VALID = v; REQ0_WRITE = wr; REQ0_ADDR = a; REQ0_WDATA = d; REQ0_WSTRB = s;
    end else begin
      REQ1_VALID = v; REQ1_WRITE = wr; REQ1_ADDR = a; REQ1_WDATA = d; REQ1_WSTRB = s;
    end
  endtask

  // one request on port p: wait_n = idle cycles before READY, lat = cycles from READY to RSP
  task automatic xact(input int p, input logic wr, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rr,
                      output int wait_n, output int lat);
    int t0, n;
    @(negedge clk);
    drive(p, 1'b1, wr, a, d, s);
    #1;
    n = 0;
    while (!rdy(p) && n < 100) begin @(negedge clk); #1; n++; end
    wait_n = n;
    if (n >= 100) check("req_ready_timeout", 1'b0, 1'b1);
    t0 = cyc;
    @(negedge clk);
    drive(p, 1'b0, wr, a, d, s);
    #1;
    n = 0;
    while (!rsp(p) && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) check("rsp_timeout", 1'b0, 1'b1);
    lat = cyc - t0;
    rd  = (p != 0) ? RSP1_RDATA : RSP0_RDATA;
    rr  = (p != 0) ? RSP1_RESP : RSP0_RESP;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [7:0]  gvec, gexp;
    int wn, lat, ng, n, a0, w0, r0, g;

    for (int i = 0; i < 4; i++) mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", any_out(), 1'b0);
    @(negedge clk);
    ARESETN = 1'b1;
    @(negedge clk);

    // both ports request continuously for 8 grants
    drive(0, 1'b1, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b1, 1'b0, 4'h4, '0, '0);
    ng = 0; n = 0; gvec = '0;
    #1;
    while (ng < 8 && n < 200) begin
      if (REQ0_READY) ng++;
      else if (REQ1_READY) begin gvec[ng] = 1'b1; ng++; end
      @(negedge clk); #1; n++;
    end
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 4'h4, '0, '0);
    check("tie_grant_count", ng, 8);
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
    gexp = 8'h00;
`else
    gexp = 8'hAA;
`endif
    check("tie_grant_order", gvec, gexp);
    repeat (5) @(negedge clk);

    // port 1 alone while last points at port 1
    xact(1, 1'b0, 4'h0, '0, '0, rd, rr, wn, lat);
    check("p1_alone_wait", wn, 0);
    check("p1_alone_lat", lat, 3);

    // port 0 writes, port 1 reads back
    for (int i = 0; i < 4; i++) begin
      xact(0, 1'b1, 4'(i * 4), 32'(i + 1), 4'hF, rd, rr, wn, lat);
      check($sformatf("wr%0d_lat", i), lat, 3);
      check($sformatf("wr%0d_resp", i), rr, 2'b00);
      check($sformatf("wr%0d_rdata_zero", i), rd, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b0, 4'(i * 4), '0, '0, rd, rr, wn, lat);
      check($sformatf("rd%0d_data", i), rd, 32'(i + 1));
      check($sformatf("rd%0d_resp", i), rr, 2'b00);
    end

    // AWREADY delayed by 3, then WREADY delayed by 3
    aw_delay = 3; w_delay = 0;
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    xact(0, 1'b1, 4'h4, 32'h0000_0055, 4'hF, rd, rr, wn, lat);
    check("awdly_aw_hs", aw_hs_cnt - a0, 1);
    check("awdly_w_hs", w_hs_cnt - w0, 1);
    check("awdly_lat", lat, 6);
    aw_delay = 0; w_delay = 3;
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    xact(0, 1'b1, 4'h8, 32'h0000_0066, 4'hF, rd, rr, wn, lat);
    check("wdly_aw_hs", aw_hs_cnt - a0, 1);
    check("wdly_w_hs", w_hs_cnt - w0, 1);
    check("wdly_lat", lat, 6);
    w_delay = 0;
    xact(1, 1'b0, 4'h4, '0, '0, rd, rr, wn, lat);
    check("awdly_readback", rd, 32'h0000_0055);
    xact(1, 1'b0, 4'h8, '0, '0, rd, rr, wn, lat);
    check("wdly_readback", rd, 32'h0000_0066);

    // slave error response is forwarded once
    force_err = 1'b1;
    r0 = ar_hs_cnt;
    xact(1, 1'b0, 4'h8, '0, '0, rd, rr, wn, lat);
    force_err = 1'b0;
    check("err_rdata", rd, 32'hDEAD_BEEF);
    check("err_resp", rr, 2'b10);
    check("err_no_retry", ar_hs_cnt - r0, 1);

    // reset while in WRESP
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'hC, 32'h0000_AAAA, 4'hF);
    #1;
    n = 0;
    while (!REQ0_READY && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) check("rst_req_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 4'hC, 32'h0000_AAAA, 4'hF);
    @(negedge clk);
    #1;
    check("rst_in_wresp_bready", M_AXI_BREADY, 1'b1);
    r0 = rsp0_cnt;
    ARESETN = 1'b0;
    drive(0, 1'b1, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b1, 1'b0, 4'h4, '0, '0);
    #1;
    check("rst_outputs_zero", any_out(), 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_held_outputs_zero", any_out(), 1'b0);
    @(negedge clk);
    ARESETN = 1'b1;
    n = 0; g = 2;
    while (g == 2 && n < 20) begin
      @(negedge clk); #1; n++;
      g = REQ0_READY ? 0 : (REQ1_READY ? 1 : 2);
    end
    check("rst_first_tie_winner", g, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 4'h4, '0, '0);
    repeat (6) @(negedge clk);
    check("rst_no_rsp_pulse", rsp0_cnt - r0, 1);

    check("bready_after_both_hs", bready_bad, 0);
    check("ready_rsp_no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
